signed_div_ctrl: RTL

SIGNED_DIV_CTRL -- requirements
Module: signed_div_ctrl

---
 rtl/alu_pkg.sv | 16 +
 rtl/cond_neg.sv | 13 +
 rtl/signed_div_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the signed divide controller: FSM state encoding and
// default geometry (operand width, watchdog limit).
package alu_pkg;

  localparam int unsigned DefWidth         = 32;
  localparam int unsigned DefTimeoutCycles = 80;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StFix,
    StResp
  } divState_e;

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negation; the most negative value maps onto
// itself, which reads as 2^(WIDTH-1) when treated as unsigned.
module cond_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? -value : value;

endmodule

// File: rtl/signed_div_ctrl.sv
// Sign-handling controller wrapped around an external iterative unsigned divider.
// Define DIV_ZERO_BYPASS_EN to answer zero-divisor requests without using the core.
module signed_div_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = DefWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_zero,
  output logic             out_timeout,
  output logic             core_start,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder
);

  localparam int unsigned     WdogW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);
  localparam logic [WdogW-1:0] WdogOne  = WdogW'(1);

  divState_e stateQ, stateD;

  logic [WIDTH-1:0] opAQ, opBQ;
  logic [WIDTH-1:0] quotQ, remQ;
  logic             quotNegQ, remNegQ;
  logic             divZeroQ, timeoutQ;
  logic [WdogW-1:0] wdogQ;

  logic [WIDTH-1:0] dividendMag, divisorMag;
  logic [WIDTH-1:0] quotFixed, remFixed;
  logic             dividendSign, divisorSign;
  logic             divisorZero;
  logic             accept;
  logic             wdogDone;

  assign dividendSign = in_signed & in_dividend[WIDTH-1];
  assign divisorSign  = in_signed & in_divisor[WIDTH-1];
  assign divisorZero  = (in_divisor == '0);
  assign accept       = in_valid & in_ready;
  assign wdogDone     = (wdogQ == WdogLast);

  cond_neg #(.WIDTH(WIDTH)) u_negDividend (
    .value  (in_dividend),
    .neg    (dividendSign),
    .result (dividendMag)
  );

  cond_neg #(.WIDTH(WIDTH)) u_negDivisor (
    .value  (in_divisor),
    .neg    (divisorSign),
    .result (divisorMag)
  );

  cond_neg #(.WIDTH(WIDTH)) u_negQuot (
    .value  (core_quotient),
    .neg    (quotNegQ),
    .result (quotFixed)
  );

  cond_neg #(.WIDTH(WIDTH)) u_negRem (
    .value  (core_remainder),
    .neg    (remNegQ),
    .result (remFixed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (in_valid) begin
`ifdef DIV_ZERO_BYPASS_EN
          stateD = divisorZero ? StResp : StLaunch;
`else
          stateD = StLaunch;
`endif
        end
      end
      StLaunch: stateD = StWait;
      StWait: begin
        // A completion in the final watchdog cycle still wins over the abort.
        if (core_done) begin
          stateD = StFix;
        end else if (wdogDone) begin
          stateD = StResp;
        end
      end
      StFix:  stateD = StResp;
      StResp: begin
        if (out_ready) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = (stateQ == StIdle);
    core_start = (stateQ == StLaunch);
    out_valid  = (stateQ == StResp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opAQ     <= '0;
      opBQ     <= '0;
      quotQ    <= '0;
      remQ     <= '0;
      quotNegQ <= 1'b0;
      remNegQ  <= 1'b0;
      divZeroQ <= 1'b0;
      timeoutQ <= 1'b0;
      wdogQ    <= '0;
    end else begin
      if (accept) begin
        opAQ     <= dividendMag;
        opBQ     <= divisorMag;
        quotNegQ <= dividendSign ^ divisorSign;
        remNegQ  <= dividendSign;
        divZeroQ <= divisorZero;
        timeoutQ <= 1'b0;
        quotQ    <= '0;
        remQ     <= '0;
`ifdef DIV_ZERO_BYPASS_EN
        if (divisorZero) begin
          quotQ <= '1;
          remQ  <= in_dividend;
        end
`endif
      end

      if (stateQ == StLaunch) begin
        wdogQ <= '0;
      end

      if (stateQ == StWait) begin
        wdogQ <= wdogQ + WdogOne;
        if (!core_done && wdogDone) begin
          timeoutQ <= 1'b1;
          quotQ    <= '0;
          remQ     <= '0;
        end
      end

      if (stateQ == StFix) begin
        quotQ <= quotFixed;
        remQ  <= remFixed;
      end
    end
  end

  assign core_dividend = opAQ;
  assign core_divisor  = opBQ;
  assign out_quotient  = quotQ;
  assign out_remainder = remQ;
  assign out_div_zero  = divZeroQ;
  assign out_timeout   = timeoutQ;

endmodule
